// File: rtl/alu_trojan_monitor.sv
// alu_trojan_monitor: passive checker for the 4-bit ALU tile.
// Recomputes each ALU result in two stages, counts mismatches,
// captures the first one and raises a sticky alarm at a threshold.
// Ports: clk, rst_n (sync, active-low), ena, clear, in_valid,
//   a/b/op/res/cout (observed ALU bus) ->
//   sample_cnt, mismatch_cnt, err_pulse, alarm,
//   cap_valid, cap_a, cap_b, cap_op, cap_res, cap_cout.
module alu_trojan_monitor #(
  parameter int ALARM_THRESH = 3,
  parameter int CNT_W        = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             in_valid,
  input  logic [3:0]       a,
  input  logic [3:0]       b,
  input  logic [1:0]       op,
  input  logic [3:0]       res,
  input  logic             cout,
  input  logic             clear,
  output logic [CNT_W-1:0] sample_cnt,
  output logic [CNT_W-1:0] mismatch_cnt,
  output logic             err_pulse,
  output logic             alarm,
  output logic             cap_valid,
  output logic [3:0]       cap_a,
  output logic [3:0]       cap_b,
  output logic [1:0]       cap_op,
  output logic [3:0]       cap_res,
  output logic             cap_cout
);

  typedef enum logic [1:0] {
    IDLE, MONITOR, ALARM
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] THRESH  =
    CNT_W'(ALARM_THRESH);

  state_t state, state_nxt;

  logic       s1_valid;
  logic [3:0] s1_a, s1_b, s1_res, s1_gres;
  logic [1:0] s1_op;
  logic       s1_cout, s1_gcout;

  logic [3:0] g_res;
  logic       g_cout;
  logic       accept;
  logic       mism;
  logic       wipe;
  logic [CNT_W-1:0] mcnt_nxt;

  // reset and soft clear share one path; clear obeys ena
  assign wipe   = !rst_n || (ena && clear);
  assign accept = ena && !clear && in_valid;

  always_comb begin
    g_res  = '0;
    g_cout = 1'b0;
    unique case (1'b1)
      (op == 2'b00): {g_cout, g_res} =
        {1'b0, a} + {1'b0, b};
      (op == 2'b01): begin
        g_res  = a - b;
        g_cout = (a < b);
      end
      (op == 2'b10): g_res = a & b;
      (op == 2'b11): g_res = a | b;
      default: ;
    endcase
  end

  assign mism = s1_valid &&
    ({s1_res, s1_cout} != {s1_gres, s1_gcout});

  always_comb begin
    mcnt_nxt = mismatch_cnt;
    if (mism && mismatch_cnt != CNT_MAX)
      mcnt_nxt = mismatch_cnt + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (wipe) begin
      state <= IDLE;
    end else if (ena) begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:
        if (accept) state_nxt = MONITOR;
      MONITOR:
        if (mism && mcnt_nxt >= THRESH)
          state_nxt = ALARM;
      ALARM: state_nxt = ALARM;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    alarm = (state == ALARM);
  end

  always_ff @(posedge clk) begin
    if (wipe) begin
      s1_valid     <= 1'b0;
      s1_a         <= '0;
      s1_b         <= '0;
      s1_op        <= '0;
      s1_res       <= '0;
      s1_cout      <= 1'b0;
      s1_gres      <= '0;
      s1_gcout     <= 1'b0;
      sample_cnt   <= '0;
      mismatch_cnt <= '0;
      err_pulse    <= 1'b0;
      cap_valid    <= 1'b0;
      cap_a        <= '0;
      cap_b        <= '0;
      cap_op       <= '0;
      cap_res      <= '0;
      cap_cout     <= 1'b0;
    end else if (ena) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_a     <= a;
        s1_b     <= b;
        s1_op    <= op;
        s1_res   <= res;
        s1_cout  <= cout;
        s1_gres  <= g_res;
        s1_gcout <= g_cout;
        if (sample_cnt != CNT_MAX)
          sample_cnt <= sample_cnt + CNT_W'(1);
      end
      err_pulse    <= mism;
      mismatch_cnt <= mcnt_nxt;
      // only the first offender since reset/clear is kept
      if (mism && !cap_valid) begin
        cap_valid <= 1'b1;
        cap_a     <= s1_a;
        cap_b     <= s1_b;
        cap_op    <= s1_op;
        cap_res   <= s1_res;
        cap_cout  <= s1_cout;
      end
    end
  end

endmodule

// File: tb/tb_alu_trojan_monitor.sv
// tb_alu_trojan_monitor: vector table + scoreboard bench.
// Runs a CNT_W=8 and a CNT_W=2 instance on the same bus.
module tb_alu_trojan_monitor;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [1:0] op;
    logic [3:0] res;
    logic       cout;
    bit         mis;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, ena, in_valid, clear, cout;
  logic [3:0] a, b, res;
  logic [1:0] op;

  logic [7:0] sample_cnt, mismatch_cnt;
  logic       err_pulse, alarm, cap_valid, cap_cout;
  logic [3:0] cap_a, cap_b, cap_res;
  logic [1:0] cap_op;

  logic [1:0] s_scnt, s_mcnt, s_cop;
  logic       s_err, s_alarm, s_capv, s_ccout;
  logic [3:0] s_ca, s_cb, s_cres;

  alu_trojan_monitor #(.ALARM_THRESH(3), .CNT_W(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .ena(ena),
    .in_valid(in_valid), .a(a), .b(b), .op(op),
    .res(res), .cout(cout), .clear(clear),
    .sample_cnt(sample_cnt),
    .mismatch_cnt(mismatch_cnt),
    .err_pulse(err_pulse), .alarm(alarm),
    .cap_valid(cap_valid), .cap_a(cap_a),
    .cap_b(cap_b), .cap_op(cap_op),
    .cap_res(cap_res), .cap_cout(cap_cout)
  );

  alu_trojan_monitor #(.ALARM_THRESH(3), .CNT_W(2)) u_sat (
    .clk(clk), .rst_n(rst_n), .ena(ena),
    .in_valid(in_valid), .a(a), .b(b), .op(op),
    .res(res), .cout(cout), .clear(clear),
    .sample_cnt(s_scnt), .mismatch_cnt(s_mcnt),
    .err_pulse(s_err), .alarm(s_alarm),
    .cap_valid(s_capv), .cap_a(s_ca),
    .cap_b(s_cb), .cap_op(s_cop),
    .cap_res(s_cres), .cap_cout(s_ccout)
  );

  int nvec  = 0;
  int nfail = 0;

  vec_t sb_q[$];
  vec_t tbl[12];

  int          e_scnt, e_mcnt, e_scnt2, e_mcnt2;
  bit          e_err, e_alarm, e_alarm2, e_capv;
  logic [14:0] e_cap;

  function automatic void chk(string nm,
      logic [31:0] act, logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s @%0t: got %0h want %0h",
               nm, $time, act, exp);
    end
  endfunction

  function automatic vec_t mk(logic [3:0] va,
      logic [3:0] vb, logic [1:0] vop, bit bad);
    vec_t v;
    logic [4:0] s;
    v.a = va; v.b = vb; v.op = vop; v.cout = 1'b0;
    case (vop)
      2'b00: begin
        s = {1'b0, va} + {1'b0, vb};
        v.res = s[3:0]; v.cout = s[4];
      end
      2'b01: begin
        v.res = va - vb; v.cout = (va < vb);
      end
      2'b10: v.res = va & vb;
      default: v.res = va | vb;
    endcase
    if (bad) begin
      if ($urandom_range(0, 1) == 1)
        v.res = v.res ^ 4'($urandom_range(1, 15));
      else
        v.cout = ~v.cout;
    end
    v.mis = bad;
    return v;
  endfunction

  task automatic zero_model();
    e_scnt = 0; e_mcnt = 0; e_scnt2 = 0; e_mcnt2 = 0;
    e_err = 0; e_alarm = 0; e_alarm2 = 0;
    e_capv = 0; e_cap = '0;
    sb_q.delete();
  endtask

  task automatic model_edge(input vec_t t);
    vec_t p;
    if (!rst_n || (ena && clear)) begin
      zero_model();
    end else if (ena) begin
      e_err = 0;
      if (sb_q.size() > 0) begin
        p = sb_q.pop_front();
        if (p.mis) begin
          e_err = 1;
          if (e_mcnt < 255) e_mcnt++;
          if (e_mcnt2 < 3) e_mcnt2++;
          if (!e_capv) begin
            e_capv = 1;
            e_cap = {p.a, p.b, p.op, p.res, p.cout};
          end
          if (e_mcnt >= 3) e_alarm = 1;
          if (e_mcnt2 >= 3) e_alarm2 = 1;
        end
      end
      if (in_valid) begin
        sb_q.push_back(t);
        if (e_scnt < 255) e_scnt++;
        if (e_scnt2 < 3) e_scnt2++;
      end
    end
  endtask

  task automatic check_all();
    chk("sample_cnt", sample_cnt, e_scnt);
    chk("mismatch_cnt", mismatch_cnt, e_mcnt);
    chk("err_pulse", err_pulse, e_err);
    chk("alarm", alarm, e_alarm);
    chk("cap_valid", cap_valid, e_capv);
    chk("cap", {cap_a, cap_b, cap_op, cap_res,
                cap_cout}, e_cap);
    chk("sat_sample_cnt", s_scnt, e_scnt2);
    chk("sat_mismatch_cnt", s_mcnt, e_mcnt2);
    chk("sat_err_pulse", s_err, e_err);
    chk("sat_alarm", s_alarm, e_alarm2);
  endtask

  task automatic cyc(input bit v, input vec_t t);
    in_valid = v;
    a = t.a; b = t.b; op = t.op;
    res = t.res; cout = t.cout;
    @(posedge clk);
    #1;
    model_edge(t);
    check_all();
  endtask

  initial begin
    vec_t idle;
    int np;
    tbl[0]  = '{4'd5,  4'd3,  2'b00, 4'd8,  1'b0, 1'b0};
    tbl[1]  = '{4'd15, 4'd15, 2'b00, 4'd15, 1'b0, 1'b1};
    tbl[2]  = '{4'd9,  4'd6,  2'b00, 4'd5,  1'b1, 1'b1};
    tbl[3]  = '{4'd3,  4'd5,  2'b01, 4'd14, 1'b1, 1'b0};
    tbl[4]  = '{4'd3,  4'd12, 2'b11, 4'd15, 1'b0, 1'b0};
    tbl[5]  = '{4'd3,  4'd12, 2'b11, 4'd15, 1'b1, 1'b1};
    tbl[6]  = '{4'd12, 4'd10, 2'b10, 4'd8,  1'b0, 1'b0};
    tbl[7]  = '{4'd10, 4'd3,  2'b01, 4'd7,  1'b0, 1'b0};
    tbl[8]  = '{4'd6,  4'd3,  2'b10, 4'd2,  1'b0, 1'b0};
    tbl[9]  = '{4'd0,  4'd1,  2'b01, 4'd15, 1'b1, 1'b0};
    tbl[10] = '{4'd8,  4'd8,  2'b00, 4'd0,  1'b1, 1'b0};
    tbl[11] = '{4'd4,  4'd4,  2'b01, 4'd0,  1'b1, 1'b1};
    idle = '{4'd0, 4'd0, 2'b00, 4'd0, 1'b0, 1'b0};

    zero_model();
    rst_n = 1'b0; ena = 1'b1; clear = 1'b0;
    cyc(0, idle);
    cyc(0, idle);
    rst_n = 1'b1;

    // table pass: alarm rises with the third mismatch
    for (int i = 0; i < 12; i++) cyc(1, tbl[i]);
    cyc(0, idle);
    cyc(0, idle);
    chk("cap_first_a", cap_a, 4'd15);
    chk("alarm_held", alarm, 1'b1);

    // saturation on the narrow instance
    clear = 1'b1; cyc(0, idle); clear = 1'b0;
    np = 0;
    for (int i = 0; i < 5; i++) begin
      cyc(1, tbl[1]);
      np += int'(s_err);
    end
    cyc(0, idle);
    np += int'(s_err);
    chk("sat_pulse_count", np, 5);
    chk("sat_mcnt_final", s_mcnt, 2'd3);

    // clear with a mismatch in flight and in_valid high
    cyc(1, tbl[2]);
    clear = 1'b1; cyc(1, tbl[1]); clear = 1'b0;
    np = 0;
    for (int i = 0; i < 3; i++) begin
      cyc(0, idle);
      np += int'(err_pulse) + int'(s_err);
    end
    chk("no_err_after_clear", np, 0);

    // ena low for 3 cycles with a compare pending
    cyc(1, tbl[0]);
    cyc(1, tbl[1]);
    cyc(1, tbl[2]);
    ena = 1'b0;
    for (int i = 0; i < 3; i++) cyc(1, tbl[5]);
    ena = 1'b1;
    cyc(0, idle);
    cyc(0, idle);

    // reset with a mismatch sitting in stage 1
    cyc(1, tbl[1]);
    rst_n = 1'b0; cyc(1, tbl[2]);
    ena = 1'b0; cyc(1, tbl[2]);
    ena = 1'b1; rst_n = 1'b1;
    np = 0;
    for (int i = 0; i < 3; i++) begin
      cyc(0, idle);
      np += int'(err_pulse) + int'(s_err);
    end
    chk("no_err_after_reset", np, 0);

    // random traffic
    for (int i = 0; i < 80; i++) begin
      ena   = ($urandom_range(0, 7) != 0);
      clear = ($urandom_range(0, 29) == 0);
      cyc(($urandom_range(0, 3) != 0),
          mk(4'($urandom_range(0, 15)),
             4'($urandom_range(0, 15)),
             2'($urandom_range(0, 3)),
             ($urandom_range(0, 3) == 0)));
    end
    ena = 1'b1; clear = 1'b0;
    cyc(0, idle);
    cyc(0, idle);

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nfail);
    $finish;
  end

endmodule
